// File: rtl/vend_pkg.sv
// Shared definitions for the coin payout controller: denomination indices,
// the value table and the controller state encoding.
package vend_pkg;

  localparam int unsigned NUM_DENOM = 5;

  typedef enum logic [2:0] {
    D5   = 3'd0,
    D10  = 3'd1,
    D20  = 3'd2,
    D50  = 3'd3,
    D100 = 3'd4
  } denom_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam logic [7:0] DENOM_VALUE [NUM_DENOM] = '{8'd5, 8'd10, 8'd20, 8'd50, 8'd100};

  function automatic logic [7:0] denom_value(input denom_e d);
    logic [7:0] v;
    case (d)
      D5:      v = DENOM_VALUE[0];
      D10:     v = DENOM_VALUE[1];
      D20:     v = DENOM_VALUE[2];
      D50:     v = DENOM_VALUE[3];
      D100:    v = DENOM_VALUE[4];
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_denom_pick.sv
// Picks the largest denomination that still fits the remaining amount and has stock.
module change_denom_pick
  import vend_pkg::*;
(
  input  logic [7:0]           remaining_i,
  input  logic [NUM_DENOM-1:0] nonzero_i,
  output logic                 found_o,
  output denom_e               idx_o
);

  // Ascending scan; the last qualifying entry is the largest denomination.
  always_comb begin
    found_o = 1'b0;
    idx_o   = D5;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if (nonzero_i[i] && (denom_value(denom_e'(i[2:0])) <= remaining_i)) begin
        found_o = 1'b1;
        idx_o   = denom_e'(i[2:0]);
      end
    end
  end

endmodule

// File: rtl/change_payout_ctrl.sv
// Coin payout controller: greedy change dispensing from five hoppers with
// per-coin eject handshake, ack timeout fault and shortfall reporting.
module change_payout_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  input  logic       stock_load,
  input  logic [2:0] stock_sel,
  input  logic [3:0] stock_qty,
  output logic       eject_req,
  output logic [2:0] eject_sel,
  input  logic       eject_ack,
  output logic       busy,
  output logic       done,
  output logic [7:0] shortfall,
  output logic       fault,
  input  logic       fault_clr,
  output logic [4:0] stock_empty
);

  localparam logic [7:0] TIMER_LAST = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] timer_q, timer_d;
  denom_e     sel_q, sel_d;
  logic [7:0] shortfall_q, shortfall_d;
  logic       ready_q;
  logic [3:0] stock_q [NUM_DENOM];
  logic [3:0] stock_d [NUM_DENOM];

  logic                 pick_found;
  denom_e               pick_idx;
  logic [NUM_DENOM-1:0] nonzero;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      nonzero[i]     = (stock_q[i] != '0);
      stock_empty[i] = (stock_q[i] == '0);
    end
  end

  change_denom_pick u_pick (
    .remaining_i (remaining_q),
    .nonzero_i   (nonzero),
    .found_o     (pick_found),
    .idx_o       (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    timer_d     = timer_q;
    sel_d       = sel_q;
    shortfall_d = shortfall_q;
    stock_d     = stock_q;

    case (state_q)
      ST_IDLE: begin
        if (stock_load && (stock_sel < 3'(NUM_DENOM))) begin
          stock_d[stock_sel] = stock_qty;
        end
        if (req_valid && ready_q) begin
          remaining_d = req_amount;
          shortfall_d = '0;
          state_d     = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          timer_d = '0;
          state_d = ST_EJECT;
        end else begin
          shortfall_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      ST_EJECT: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (eject_ack) begin
          remaining_d = remaining_q - denom_value(sel_q);
          if (stock_q[sel_q] != '0) begin
            stock_d[sel_q] = stock_q[sel_q] - 4'd1;
          end
          state_d = ST_SELECT;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (fault_clr) begin
          shortfall_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ready is registered from the next state so it stays low through reset
  // and rises on the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      timer_q     <= '0;
      sel_q       <= D5;
      shortfall_q <= '0;
      ready_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_DENOM; i++) begin
        stock_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      timer_q     <= timer_d;
      sel_q       <= sel_d;
      shortfall_q <= shortfall_d;
      ready_q     <= (state_d == ST_IDLE);
      for (int unsigned i = 0; i < NUM_DENOM; i++) begin
        stock_q[i] <= stock_d[i];
      end
    end
  end

  assign req_ready = ready_q;
  assign eject_req = (state_q == ST_EJECT);
  assign eject_sel = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fault     = (state_q == ST_FAULT);
  assign shortfall = shortfall_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed bench for change_payout_ctrl with hand-computed expectations.
module tb_change_payout_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [7:0] req_amount;
  logic       req_ready;
  logic       stock_load;
  logic [2:0] stock_sel;
  logic [3:0] stock_qty;
  logic       eject_req;
  logic [2:0] eject_sel;
  logic       eject_ack;
  logic       busy;
  logic       done;
  logic [7:0] shortfall;
  logic       fault;
  logic       fault_clr;
  logic [4:0] stock_empty;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  change_payout_ctrl #(.ACK_TIMEOUT(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_amount  (req_amount),
    .req_ready   (req_ready),
    .stock_load  (stock_load),
    .stock_sel   (stock_sel),
    .stock_qty   (stock_qty),
    .eject_req   (eject_req),
    .eject_sel   (eject_sel),
    .eject_ack   (eject_ack),
    .busy        (busy),
    .done        (done),
    .shortfall   (shortfall),
    .fault       (fault),
    .fault_clr   (fault_clr),
    .stock_empty (stock_empty)
  );

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] sel, input logic [3:0] qty);
    stock_load = 1'b1;
    stock_sel  = sel;
    stock_qty  = qty;
    @(negedge clk);
    stock_load = 1'b0;
  endtask

  task automatic accept(input string tag, input logic [7:0] amt);
    req_valid  = 1'b1;
    req_amount = amt;
    check8({tag, "_ready"}, 8'(req_ready), 8'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_eject(input string tag);
    for (int c = 0; c < 20 && !eject_req; c++) @(negedge clk);
    check8({tag, "_eject_seen"}, 8'(eject_req), 8'd1);
  endtask

  // seq holds coin k's expected index in bits [3k+2:3k].
  task automatic run_payout(input string tag, input logic [7:0] amt, input int n,
                            input logic [14:0] seq, input logic [7:0] sf);
    int   coins;
    logic got_done;
    coins    = 0;
    got_done = 1'b0;
    accept(tag, amt);
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        if (eject_req) begin
          if (coins < n) check8({tag, "_sel"}, 8'(eject_sel), 8'(seq[3*coins +: 3]));
          @(negedge clk);
          eject_ack = 1'b1;
          @(negedge clk);
          eject_ack = 1'b0;
          check8({tag, "_gap"}, 8'(eject_req), 8'd0);
          coins++;
        end
        @(negedge clk);
      end
    end
    check8({tag, "_done"}, 8'(got_done), 8'd1);
    check8({tag, "_coins"}, 8'(coins), 8'(n));
    check8({tag, "_shortfall"}, shortfall, sf);
    @(negedge clk);
    check8({tag, "_done_low"}, 8'(done), 8'd0);
    check8({tag, "_ready_back"}, 8'(req_ready), 8'd1);
  endtask

  initial begin
    int ej;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_amount = '0;
    stock_load = 1'b0;
    stock_sel  = '0;
    stock_qty  = '0;
    eject_ack  = 1'b0;
    fault_clr  = 1'b0;

    // Reset values
    @(negedge clk);
    check8("rst_eject_req", 8'(eject_req), 8'd0);
    check8("rst_eject_sel", 8'(eject_sel), 8'd0);
    check8("rst_done", 8'(done), 8'd0);
    check8("rst_busy", 8'(busy), 8'd0);
    check8("rst_fault", 8'(fault), 8'd0);
    check8("rst_shortfall", shortfall, 8'd0);
    check8("rst_empty", 8'(stock_empty), 8'h1f);
    check8("rst_ready", 8'(req_ready), 8'd0);
    reset_n = 1'b1;
    #1 check8("rst_ready_before_clk", 8'(req_ready), 8'd0);
    @(negedge clk);
    check8("rst_ready_after_clk", 8'(req_ready), 8'd1);

    // All hoppers full, 185 -> 100, 50, 20, 10, 5
    for (int i = 0; i < 5; i++) load(3'(i), 4'd15);
    check8("full_empty", 8'(stock_empty), 8'h00);
    run_payout("p185", 8'd185, 5, {3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4}, 8'd0);
    check8("p185_empty", 8'(stock_empty), 8'h00);

    // 37 -> 20, 10, 5 with residue 2
    run_payout("p37", 8'd37, 3, {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2}, 8'd2);

    // No 100s, 200 -> four 50s
    load(3'd4, 4'd0);
    for (int i = 0; i < 4; i++) load(3'(i), 4'd15);
    check8("no100_empty", 8'(stock_empty), 8'h10);
    run_payout("p200", 8'd200, 4, {3'd0, 3'd0, 3'd3, 3'd3, 3'd3, 3'd3}, 8'd0);

    // Single 100 coin, 200 -> one 100, shortfall 100, hopper drains to empty
    load(3'd4, 4'd1);
    for (int i = 0; i < 4; i++) load(3'(i), 4'd0);
    check8("one100_empty", 8'(stock_empty), 8'h0f);
    run_payout("p200b", 8'd200, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}, 8'd100);
    check8("drained_empty", 8'(stock_empty), 8'h1f);

    // No stock, 40 -> done on the second edge after acceptance, shortfall 40
    accept("p40", 8'd40);
    check8("p40_busy", 8'(busy), 8'd1);
    check8("p40_done_early", 8'(done), 8'd0);
    check8("p40_no_eject", 8'(eject_req), 8'd0);
    @(negedge clk);
    check8("p40_done", 8'(done), 8'd1);
    check8("p40_shortfall", shortfall, 8'd40);
    check8("p40_no_eject2", 8'(eject_req), 8'd0);
    @(negedge clk);
    check8("p40_done_low", 8'(done), 8'd0);
    check8("p40_idle", 8'(busy), 8'd0);
    eject_ack = 1'b1;
    @(negedge clk);
    eject_ack = 1'b0;
    @(negedge clk);
    check8("stray_ack_busy", 8'(busy), 8'd0);
    check8("hold_shortfall", shortfall, 8'd40);
    load(3'd5, 4'd7);
    check8("bad_sel_empty", 8'(stock_empty), 8'h1f);

    // Ack timeout -> fault after 8 eject cycles, then clear
    load(3'd2, 4'd3);
    accept("to", 8'd40);
    ej = 0;
    for (int c = 0; c < 50 && !fault; c++) begin
      if (eject_req) ej++;
      @(negedge clk);
    end
    check8("to_fault", 8'(fault), 8'd1);
    check8("to_cycles", 8'(ej), 8'd8);
    check8("to_eject_req", 8'(eject_req), 8'd0);
    check8("to_ready", 8'(req_ready), 8'd0);
    check8("to_busy", 8'(busy), 8'd1);
    load(3'd4, 4'd5);
    check8("to_fault_hold", 8'(fault), 8'd1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check8("clr_done", 8'(done), 8'd1);
    check8("clr_shortfall", shortfall, 8'd40);
    check8("clr_fault", 8'(fault), 8'd0);
    @(negedge clk);
    check8("clr_ready", 8'(req_ready), 8'd1);
    check8("clr_stock_kept", 8'(stock_empty), 8'h1b);
    run_payout("p60", 8'd60, 3, {3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2}, 8'd0);
    check8("p60_empty", 8'(stock_empty), 8'h1f);

    // Ack on the last allowed cycle wins over timeout
    load(3'd2, 4'd1);
    accept("aw", 8'd20);
    wait_eject("aw");
    for (int c = 0; c < 7; c++) @(negedge clk);
    check8("aw_eject_last", 8'(eject_req), 8'd1);
    check8("aw_fault_pre", 8'(fault), 8'd0);
    eject_ack = 1'b1;
    @(negedge clk);
    eject_ack = 1'b0;
    check8("aw_fault", 8'(fault), 8'd0);
    check8("aw_eject_low", 8'(eject_req), 8'd0);
    @(negedge clk);
    check8("aw_done", 8'(done), 8'd1);
    check8("aw_shortfall", shortfall, 8'd0);
    check8("aw_empty", 8'(stock_empty), 8'h1f);
    @(negedge clk);

    // Reset during EJECT
    load(3'd3, 4'd2);
    accept("mr", 8'd50);
    wait_eject("mr");
    #2 reset_n = 1'b0;
    #1;
    check8("mr_eject_req", 8'(eject_req), 8'd0);
    check8("mr_empty", 8'(stock_empty), 8'h1f);
    check8("mr_busy", 8'(busy), 8'd0);
    check8("mr_ready", 8'(req_ready), 8'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check8("mr_ready_back", 8'(req_ready), 8'd1);
    load(3'd2, 4'd3);
    run_payout("p20", 8'd20, 1, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2}, 8'd0);
    check8("p20_empty", 8'(stock_empty), 8'h1b);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
